stopwatch_datapath: RTL
=======================

Name: stopwatch_datapath

Overview:
- Datapath that executes the strobes issued by the stopwatch/timer control FSM.
- Owns the prescaler, the BCD mm:ss stopwatch count, the countdown timer value, and a circular lap-time buffer.
- Drives the time_up flag back to the FSM.
- Muxes the 4-digit BCD display according to output_select.

Parameters:
- TICK_DIV, 1000: clk cycles per 1-second tick; must be >= 2.
- LAP_DEPTH, 4: number of lap entries; power of 2, >= 2.

Ports:
- clk  input  1  clock.
- nrst  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear of stopwatch, timer, prescaler and flag.
- enable  input  1  stopwatch count-up enable.
- read  input  1  advance lap read pointer, one step per asserted cycle.
- write  input  1  push current stopwatch value into lap buffer, one entry per asserted cycle.
- enable_increment  input  1  timer set mode.
- enable_decrement  input  1  timer countdown enable.
- set_inc  input  1  single-cycle debounced pulse: add one minute to the timer while in set mode.
- output_select  input  2  0 = blank, 1 = stopwatch, 2 = lap entry, 3 = timer.
- flag  output  1  timer reached 00:00 while counting down; sticky.
- display  output  16  BCD digits {m10, m1, s10, s1}.
- lap_count  output  $clog2(LAP_DEPTH)+1  number of valid lap entries.

Behaviour:
- Reset (nrst low, async): all state cleared.
  - Outputs: display = 0, flag = 0, lap_count = 0.
  - Pointers and prescaler = 0.
- Priority, highest first: clear > write/read > count enables.
- clear also wins against a same-cycle set_inc.
- Prescaler:
  - Runs only while enable or enable_decrement is high.
  - Counts 0..TICK_DIV-1, then wraps.
  - tick = 1 for the single cycle the count equals TICK_DIV-1.
  - Holds its value when both enables are low; reset to 0 by clear.
- Stopwatch count:
  - BCD mm:ss, digit ranges s1 0-9, s10 0-5, m1 0-9, m10 0-5.
  - Increments on tick & enable; 59:59 + 1 wraps to 00:00.
- Timer value:
  - set_inc & enable_increment adds 01:00; 59:xx + 1 min wraps to 00:xx.
  - tick & enable_decrement & value != 0 decrements by one second with BCD borrow (01:00 -> 00:59).
  - No decrement at 00:00.
- flag:
  - Registered; set the cycle after enable_decrement is high while the timer value == 00:00.
  - Includes a timer entered at 00:00.
  - Stays high until clear or reset.
- Lap buffer:
  - write stores the stopwatch value at wr_ptr, then wr_ptr += 1 (mod LAP_DEPTH).
  - lap_count saturates at LAP_DEPTH; when full, the oldest entry is overwritten.
  - Every write sets rd_ptr to the newest entry.
  - read moves rd_ptr to the next-older valid entry; after the oldest it wraps to the newest.
  - read with lap_count == 0 has no effect; the lap display shows 0000.
  - The buffer is not affected by clear; only reset empties it.
- Display:
  - Combinational mux of registered values; no added latency.
  - Selections 1 and 3 show the live counts.
  - A write in cycle N is visible through select 2 from cycle N+1.

Optional Feature:
- Macro: STOPWATCH_SATURATE_EN.
- Defined: the stopwatch holds at 59:59 once reached; further ticks are ignored.
- Undefined: the stopwatch wraps to 00:00.
- The timer and lap behaviour are identical in both builds.

Decomposition:
- Package stopwatch_pkg contains:
  - bcd_time_t: packed struct of four 4-bit digits.
  - disp_sel_e: DISP_BLANK = 0, DISP_STOPWATCH = 1, DISP_LAPS = 2, DISP_TIMER = 3.
  - Constants BCD_ZERO and BCD_MAX (59:59).
- Sub-module bcd_time_counter: BCD mm:ss register.
  - Controls: clr, up, down, add_min, sat.
  - Two instances, one for the stopwatch and one for the timer.

Test Plan:
- TICK_DIV = 4; enable high for 4*75 cycles -> display (sel 1) = 0x0115.
- Stopwatch preloaded via ticks to 59:59; one more tick -> 0x0000. With STOPWATCH_SATURATE_EN -> stays 0x5959.
- Three set_inc pulses under enable_increment, then enable_decrement for 4*180 cycles -> display (sel 3) = 0x0000; flag rises the next cycle and stays high until clear.
- Five writes with stopwatch values 1, 2, 3, 4, 5 s and LAP_DEPTH = 4 -> lap_count = 4. Select 2 shows 0x0005; successive reads show 0004, 0003, 0002, then 0005.
- clear asserted mid-count with enable held high -> stopwatch = 0000, prescaler restarts, and the first tick arrives 4 cycles after clear drops. lap_count is unchanged.
- nrst pulled low mid-countdown -> display, flag and lap_count go to 0 immediately (asynchronously).

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types, constants and BCD helpers for the stopwatch/timer datapath.
package stopwatch_pkg;

  typedef struct packed {
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
  } bcd_time_t;

  typedef enum logic [1:0] {
    DISP_BLANK     = 2'd0,
    DISP_STOPWATCH = 2'd1,
    DISP_LAPS      = 2'd2,
    DISP_TIMER     = 2'd3
  } disp_sel_e;

  localparam bcd_time_t BCD_ZERO = bcd_time_t'(16'h0000);
  localparam bcd_time_t BCD_MAX  = bcd_time_t'(16'h5959);

  // One second forward with BCD carries; 59:59 wraps to 00:00.
  function automatic bcd_time_t bcd_inc_sec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.s1 != 4'd9) begin
      r.s1 = t.s1 + 4'd1;
    end else begin
      r.s1 = 4'd0;
      if (t.s10 != 4'd5) begin
        r.s10 = t.s10 + 4'd1;
      end else begin
        r.s10 = 4'd0;
        if (t.m1 != 4'd9) begin
          r.m1 = t.m1 + 4'd1;
        end else begin
          r.m1  = 4'd0;
          r.m10 = (t.m10 == 4'd5) ? 4'd0 : t.m10 + 4'd1;
        end
      end
    end
    return r;
  endfunction

  // One second back with BCD borrows; the caller never passes 00:00.
  function automatic bcd_time_t bcd_dec_sec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.s1 != 4'd0) begin
      r.s1 = t.s1 - 4'd1;
    end else begin
      r.s1 = 4'd9;
      if (t.s10 != 4'd0) begin
        r.s10 = t.s10 - 4'd1;
      end else begin
        r.s10 = 4'd5;
        if (t.m1 != 4'd0) begin
          r.m1 = t.m1 - 4'd1;
        end else begin
          r.m1  = 4'd9;
          r.m10 = t.m10 - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// BCD mm:ss register with clear, count up/down and add-one-minute controls.
// Control priority: clr > add_min > down > up.
module bcd_time_counter
  import stopwatch_pkg::*;
(
  input  logic      clk,
  input  logic      nrst,
  input  logic      clr,
  input  logic      up,
  input  logic      down,
  input  logic      add_min,
  input  logic      sat,
  output bcd_time_t value
);

  bcd_time_t next_value;

  // Next-value selection; down refuses to go below 00:00, up may hold at 59:59.
  always_comb begin
    next_value = value;
    if (clr) begin
      next_value = BCD_ZERO;
    end else if (add_min) begin
      if (value.m1 == 4'd9) begin
        next_value.m1  = 4'd0;
        next_value.m10 = (value.m10 == 4'd5) ? 4'd0 : value.m10 + 4'd1;
      end else begin
        next_value.m1 = value.m1 + 4'd1;
      end
    end else if (down) begin
      if (value != BCD_ZERO) begin
        next_value = bcd_dec_sec(value);
      end
    end else if (up) begin
      if (!(sat && (value == BCD_MAX))) begin
        next_value = bcd_inc_sec(value);
      end
    end
  end

  // Time register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      value <= BCD_ZERO;
    end else begin
      value <= next_value;
    end
  end

endmodule

// File: rtl/stopwatch_datapath.sv
// Stopwatch/timer datapath: prescaler, stopwatch and timer counts, lap ring
// buffer, sticky time-up flag and display mux.
// Build option: define STOPWATCH_SATURATE_EN to hold the stopwatch at 59:59.
// Strobe priority: clear > write/read > counting; a cycle carrying a lap
// write or read does not advance the prescaler or either count.
module stopwatch_datapath
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = 1000,
  parameter int LAP_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         clear,
  input  logic                         enable,
  input  logic                         read,
  input  logic                         write,
  input  logic                         enable_increment,
  input  logic                         enable_decrement,
  input  logic                         set_inc,
  input  logic [1:0]                   output_select,
  output logic                         flag,
  output logic [15:0]                  display,
  output logic [$clog2(LAP_DEPTH):0]   lap_count
);

  localparam int PW  = $clog2(TICK_DIV);
  localparam int AW  = $clog2(LAP_DEPTH);
  localparam int LCW = AW + 1;
  localparam logic [LCW-1:0] LAP_FULL = LCW'(LAP_DEPTH);

`ifdef STOPWATCH_SATURATE_EN
  localparam logic SW_SAT = 1'b1;
`else
  localparam logic SW_SAT = 1'b0;
`endif

  logic [PW-1:0] presc;
  logic          count_ok;
  logic          presc_run;
  logic          tick;
  bcd_time_t     sw_value;
  bcd_time_t     tm_value;
  bcd_time_t     laps [LAP_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] oldest;

  assign count_ok  = !clear && !write && !read;
  assign presc_run = count_ok && (enable || enable_decrement);
  assign tick      = presc_run && (presc == PW'(TICK_DIV - 1));
  assign oldest    = wr_ptr - lap_count[AW-1:0];

  // Prescaler: free-runs 0..TICK_DIV-1 while either count is enabled.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      presc <= '0;
    end else if (clear) begin
      presc <= '0;
    end else if (presc_run) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  bcd_time_counter u_stopwatch (
    .clk     (clk),
    .nrst    (nrst),
    .clr     (clear),
    .up      (tick && enable),
    .down    (1'b0),
    .add_min (1'b0),
    .sat     (SW_SAT),
    .value   (sw_value)
  );

  bcd_time_counter u_timer (
    .clk     (clk),
    .nrst    (nrst),
    .clr     (clear),
    .up      (1'b0),
    .down    (tick && enable_decrement),
    .add_min (count_ok && enable_increment && set_inc),
    .sat     (1'b0),
    .value   (tm_value)
  );

  // Sticky time-up flag, raised whenever the countdown is enabled at 00:00.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      flag <= 1'b0;
    end else if (clear) begin
      flag <= 1'b0;
    end else if (enable_decrement && (tm_value == BCD_ZERO)) begin
      flag <= 1'b1;
    end
  end

  // Lap ring buffer: write captures the stopwatch, read walks newest to oldest.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < LAP_DEPTH; i++) begin
        laps[i] <= BCD_ZERO;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      lap_count <= '0;
    end else if (!clear) begin
      if (write) begin
        laps[wr_ptr] <= sw_value;
        rd_ptr       <= wr_ptr;
        wr_ptr       <= wr_ptr + AW'(1);
        if (lap_count != LAP_FULL) begin
          lap_count <= lap_count + LCW'(1);
        end
      end else if (read && (lap_count != '0)) begin
        rd_ptr <= (rd_ptr == oldest) ? wr_ptr - AW'(1) : rd_ptr - AW'(1);
      end
    end
  end

  // Display mux straight from registered state.
  always_comb begin
    display = 16'h0000;
    case (disp_sel_e'(output_select))
      DISP_BLANK:     display = 16'h0000;
      DISP_STOPWATCH: display = sw_value;
      DISP_LAPS:      display = (lap_count == '0) ? 16'h0000 : laps[rd_ptr];
      DISP_TIMER:     display = tm_value;
      default:        display = 16'h0000;
    endcase
  end

endmodule
